// File: rtl/fgcg_pipe_scheduler.sv
// Fine/coarse clock-gating scheduler: SLEEP/WAKE/RUN FSM plus a valid shift register for per-stage enables.
// Optional FGCG_SCHED_STATS_EN macro adds a saturating gated_cnt output counting SLEEP cycles.
module fgcg_pipe_scheduler #(
   parameter int STAGES      = 4,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              valid_in,
   input  logic              stall,
   output logic              ready,
   output logic [STAGES-1:0] stage_en,
   output logic              cg_en,
   output logic              valid_out,
   output logic              busy
`ifdef FGCG_SCHED_STATS_EN
   ,
   output logic [15:0]       gated_cnt
`endif
);

   typedef enum logic [1:0] {SLEEP, WAKE, RUN} state_e;

   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
   localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [STAGES-1:0] vpipe_q, vpipe_d;
   logic [7:0]        idle_q, idle_d;
   logic [3:0]        wake_q, wake_d;
   logic              accept;
   logic              pipe_idle;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= SLEEP;
         vpipe_q <= '0;
         idle_q  <= '0;
         wake_q  <= '0;
      end else begin
         state_q <= state_d;
         vpipe_q <= vpipe_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
      end
   end

   // Idle means nothing in flight and nothing entering; stall does not matter.
   assign pipe_idle = (vpipe_q == '0) && !accept;

   always_comb begin
      state_d = state_q;
      vpipe_d = vpipe_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
         SLEEP: begin
            wake_d = '0;
            idle_d = '0;
            if (valid_in) state_d = WAKE;
         end
         WAKE: begin
            if (wake_q == WAKE_LAST) begin
               state_d = RUN;
               wake_d  = '0;
            end else begin
               wake_d = wake_q + 4'd1;
            end
         end
         RUN: begin
            if (!stall) vpipe_d = {vpipe_q[STAGES-2:0], accept};
            // Only gate on an empty pipe, so in-flight data is never stranded.
            if (pipe_idle) begin
               if (idle_q == IDLE_LAST) begin
                  state_d = SLEEP;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_q + 8'd1;
               end
            end else begin
               idle_d = '0;
            end
         end
         default: state_d = SLEEP;
      endcase
   end

   always_comb begin
      cg_en    = (state_q != SLEEP);
      ready    = (state_q == RUN) && !stall;
      accept   = valid_in && ready;
      stage_en = '0;
      if (cg_en && !stall) stage_en = {vpipe_q[STAGES-2:0], accept};
   end

   assign valid_out = vpipe_q[STAGES-1];
   assign busy      = |vpipe_q;

`ifdef FGCG_SCHED_STATS_EN
   logic [15:0] gated_q, gated_d;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) gated_q <= '0;
      else       gated_q <= gated_d;
   end

   always_comb begin
      gated_d = gated_q;
      if (state_q == SLEEP && gated_q != 16'hFFFF) gated_d = gated_q + 16'd1;
   end

   assign gated_cnt = gated_q;
`endif

endmodule

// File: tb/tb_fgcg_pipe_scheduler.sv
// Directed bench for fgcg_pipe_scheduler at default parameters (STAGES=4, IDLE=8, WAKE=2).
// obs packs {cg_en, ready, valid_out, busy, stage_en[3:0]} for compact expected vectors.
module tb_fgcg_pipe_scheduler;

   logic       clk = 1'b0;
   logic       rstb;
   logic       valid_in;
   logic       stall;
   logic       ready;
   logic [3:0] stage_en;
   logic       cg_en;
   logic       valid_out;
   logic       busy;
`ifdef FGCG_SCHED_STATS_EN
   logic [15:0] gated_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] obs;
   assign obs = {cg_en, ready, valid_out, busy, stage_en};

   fgcg_pipe_scheduler #(.STAGES(4), .IDLE_CYCLES(8), .WAKE_CYCLES(2)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .valid_in  (valid_in),
      .stall     (stall),
      .ready     (ready),
      .stage_en  (stage_en),
      .cg_en     (cg_en),
      .valid_out (valid_out),
      .busy      (busy)
`ifdef FGCG_SCHED_STATS_EN
      ,
      .gated_cnt (gated_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstb = 1'b0; valid_in = 1'b0; stall = 1'b0;
      #2;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL reset_hold obs=%b exp=%b", obs, 8'b0000_0000); end
      valid_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL reset_vin obs=%b exp=%b", obs, 8'b0000_0000); end
      valid_in = 1'b0;
      #2 rstb = 1'b1;
      #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL rst_release obs=%b exp=%b", obs, 8'b0000_0000); end
      for (int c = 0; c < 20; c++) begin
         step();
         n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL sleep_idle c=%0d obs=%b exp=%b", c, obs, 8'b0000_0000); end
      end
   endtask

   task automatic test_wake();
      valid_in = 1'b1; #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL wake_e0 obs=%b exp=%b", obs, 8'b0000_0000); end
      step();
      n_tests++; if (obs !== 8'b1000_0000) begin n_fail++; $display("FAIL wake_e1 obs=%b exp=%b", obs, 8'b1000_0000); end
      step();
      n_tests++; if (obs !== 8'b1000_0000) begin n_fail++; $display("FAIL wake_e2 obs=%b exp=%b", obs, 8'b1000_0000); end
      step();
      n_tests++; if (obs !== 8'b1100_0001) begin n_fail++; $display("FAIL wake_accept obs=%b exp=%b", obs, 8'b1100_0001); end
      step();
      valid_in = 1'b0; #1;
      n_tests++; if (obs !== 8'b1101_0010) begin n_fail++; $display("FAIL wake_s1 obs=%b exp=%b", obs, 8'b1101_0010); end
      step();
      n_tests++; if (obs !== 8'b1101_0100) begin n_fail++; $display("FAIL wake_s2 obs=%b exp=%b", obs, 8'b1101_0100); end
      step();
      n_tests++; if (obs !== 8'b1101_1000) begin n_fail++; $display("FAIL wake_s3 obs=%b exp=%b", obs, 8'b1101_1000); end
      step();
      n_tests++; if (obs !== 8'b1111_0000) begin n_fail++; $display("FAIL wake_vout obs=%b exp=%b", obs, 8'b1111_0000); end
      step();
      n_tests++; if (obs !== 8'b1100_0000) begin n_fail++; $display("FAIL wake_drain obs=%b exp=%b", obs, 8'b1100_0000); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [11];
      exp = '{8'b1100_0001, 8'b1101_0011, 8'b1101_0111, 8'b1101_1111, 8'b1111_1111, 8'b1111_1111,
              8'b1111_1110, 8'b1111_1100, 8'b1111_1000, 8'b1111_0000, 8'b1100_0000};
      for (int c = 0; c < 11; c++) begin
         valid_in = (c < 6); #1;
         n_tests++; if (obs !== exp[c]) begin n_fail++; $display("FAIL b2b c=%0d obs=%b exp=%b", c, obs, exp[c]); end
         step();
      end
   endtask

   task automatic test_stall();
      valid_in = 1'b1; stall = 1'b0; #1;
      n_tests++; if (obs !== 8'b1100_0001) begin n_fail++; $display("FAIL stall_accept obs=%b exp=%b", obs, 8'b1100_0001); end
      step();
      valid_in = 1'b0; #1;
      n_tests++; if (obs !== 8'b1101_0010) begin n_fail++; $display("FAIL stall_pre obs=%b exp=%b", obs, 8'b1101_0010); end
      step();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (obs !== 8'b1001_0000) begin n_fail++; $display("FAIL stall_hold c=%0d obs=%b exp=%b", c, obs, 8'b1001_0000); end
         step();
      end
      stall = 1'b0; #1;
      n_tests++; if (obs !== 8'b1101_0100) begin n_fail++; $display("FAIL stall_resume obs=%b exp=%b", obs, 8'b1101_0100); end
      step();
      n_tests++; if (obs !== 8'b1101_1000) begin n_fail++; $display("FAIL stall_late obs=%b exp=%b", obs, 8'b1101_1000); end
      step();
      n_tests++; if (obs !== 8'b1111_0000) begin n_fail++; $display("FAIL stall_vout obs=%b exp=%b", obs, 8'b1111_0000); end
      step();
   endtask

   task automatic test_idle_sleep();
      for (int k = 1; k <= 8; k++) begin
         #1;
         n_tests++; if (obs !== 8'b1100_0000) begin n_fail++; $display("FAIL idle_run k=%0d obs=%b exp=%b", k, obs, 8'b1100_0000); end
         step();
      end
      #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL idle_sleep obs=%b exp=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_wake_abort();
      valid_in = 1'b1;
      step();
      valid_in = 1'b0; #1;
      n_tests++; if (obs !== 8'b1000_0000) begin n_fail++; $display("FAIL abort_w1 obs=%b exp=%b", obs, 8'b1000_0000); end
      step(); #1;
      n_tests++; if (obs !== 8'b1000_0000) begin n_fail++; $display("FAIL abort_w2 obs=%b exp=%b", obs, 8'b1000_0000); end
      step(); #1;
      n_tests++; if (obs !== 8'b1100_0000) begin n_fail++; $display("FAIL abort_run obs=%b exp=%b", obs, 8'b1100_0000); end
      repeat (7) step();
      #1;
      n_tests++; if (obs !== 8'b1100_0000) begin n_fail++; $display("FAIL abort_idle8 obs=%b exp=%b", obs, 8'b1100_0000); end
      step(); #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL abort_sleep obs=%b exp=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_idle_accept();
      valid_in = 1'b1;
      repeat (3) step();
      #1;
      n_tests++; if (obs !== 8'b1100_0001) begin n_fail++; $display("FAIL ia_accept obs=%b exp=%b", obs, 8'b1100_0001); end
      step();
      valid_in = 1'b0;
      repeat (4) step();
      repeat (7) step();
      valid_in = 1'b1; #1;
      n_tests++; if (obs !== 8'b1100_0001) begin n_fail++; $display("FAIL idle8_accept obs=%b exp=%b", obs, 8'b1100_0001); end
      step();
      valid_in = 1'b0; #1;
      n_tests++; if (obs !== 8'b1101_0010) begin n_fail++; $display("FAIL idle8_stay_run obs=%b exp=%b", obs, 8'b1101_0010); end
   endtask

   task automatic test_reset_mid();
      repeat (3) step();
      #1;
      n_tests++; if (obs !== 8'b1111_0000) begin n_fail++; $display("FAIL pre_reset obs=%b exp=%b", obs, 8'b1111_0000); end
      #1 rstb = 1'b0;
      #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL async_reset obs=%b exp=%b", obs, 8'b0000_0000); end
`ifdef FGCG_SCHED_STATS_EN
      n_tests++; if (gated_cnt !== 16'd0) begin n_fail++; $display("FAIL gated_rst got=%0d exp=0", gated_cnt); end
`endif
      step();
      rstb = 1'b1;
      step(); #1;
      n_tests++; if (obs !== 8'b0000_0000) begin n_fail++; $display("FAIL post_reset obs=%b exp=%b", obs, 8'b0000_0000); end
`ifdef FGCG_SCHED_STATS_EN
      n_tests++; if (gated_cnt !== 16'd1) begin n_fail++; $display("FAIL gated_1 got=%0d exp=1", gated_cnt); end
      step();
      n_tests++; if (gated_cnt !== 16'd2) begin n_fail++; $display("FAIL gated_2 got=%0d exp=2", gated_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_wake();
      test_back_to_back();
      test_stall();
      test_idle_sleep();
      test_wake_abort();
      test_idle_accept();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout tests=%0d", n_tests);
      $fatal(1);
   end

endmodule
